tick_pwm_gen: RTL and testbench
===============================

Name: tick_pwm_gen

Overview:
- Consumes the one-cycle tick strobe produced by the clock-divider stage and generates a programmable PWM output in the same clock domain.
- The divided clock is never used as a clock; it is only an enable.
- Period and duty are double-buffered and applied only at period boundaries.
- An optional soft-start state machine ramps duty from 0 to the target.

Parameters:
- WIDTH, 8: width of the period counter, the period and duty inputs, and the active-duty register.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  reset; asynchronous, active-low.
- tick_in  input  1  one-clk-cycle enable strobe from the divider; the counter advances only on cycles where it is 1.
- en  input  1  run enable; 0 forces IDLE.
- period  input  WIDTH  PWM period in ticks minus 1 (counter runs 0..period).
- duty  input  WIDTH  target high time in ticks.
- cfg_load  input  1  one-cycle strobe; captures period/duty into staging registers.
- pwm_out  output  1  PWM output, registered.
- period_end  output  1  one-cycle pulse on counter wrap.
- ramp_done  output  1  high while in RUN.
- state  output  2  current FSM state encoding.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst=0, immediate, no clock needed):
  - cnt=0, duty_act=0, pwm_out=0, period_end=0, ramp_done=0, state=IDLE.
  - Staging regs period_stg/duty_stg = all-ones/0; shadow regs period_sh/duty_sh = all-ones/0; load_pend=0.
- Staging: cfg_load=1 captures period/duty into the staging regs on that edge and sets load_pend. A later cfg_load before the boundary overwrites the staging regs; last write wins.
- Shadow update:
  - Occurs at a wrap, or on the IDLE->start transition, when load_pend=1.
  - Shadow <= staging and load_pend clears.
  - If cfg_load coincides with a wrap, the newly captured values are the ones applied at that wrap.
- Counter:
  - Advances only when tick_in=1 and state!=IDLE.
  - If cnt==period_sh, then cnt<=0 and period_end=1 for exactly that one cycle; otherwise cnt<=cnt+1.
  - tick_in=0 holds cnt.
- Output: pwm_out is registered and computed from next-state values, so it changes on the same edge as cnt. pwm_out = (cnt_next < duty_act_next).
  - duty_act=0 gives constant 0.
  - duty_act > period_sh gives constant 1.
  - period_sh=0 gives a period of 1 tick.
- FSM states: IDLE=0, RAMP=1, RUN=2; value 3 is illegal and recovers to IDLE on the next clock.
  - IDLE: cnt=0, duty_act=0, pwm_out=0. en=1 -> apply pending load, go to RAMP (or RUN, see Optional Feature).
  - RAMP: at each wrap, duty_act <= duty_act+1, saturating at duty_sh. When duty_act reaches duty_sh at a wrap -> RUN. If duty_sh=0 on entry -> RUN on the next clock.
  - RUN: duty_act <= duty_sh at each wrap, so new duty takes effect with no ramp. ramp_done=1.
  - en=0 in any state -> IDLE on the next edge: cnt=0, duty_act=0, pwm_out=0. Staging regs and load_pend are retained.
- Simultaneous events:
  - en falling together with a wrap: IDLE wins and period_end still pulses.
  - tick_in while IDLE is ignored.
- Reset mid-operation: immediate return to reset values; pending loads are lost.

Optional Feature:
- Macro: TICK_PWM_SOFT_START_EN.
- Defined: RAMP state exists as described.
- Undefined: IDLE->RUN directly, duty_act=duty_sh from the first period, and state never encodes 1.

Decomposition:
- Package pwm_pkg holds:
  - the state typedef (IDLE/RAMP/RUN, 2-bit);
  - the default WIDTH constant;
  - the reset constants for period (all-ones) and duty (0).
- Sub-module tick_period_counter is natural: it holds cnt and generates the wrap, with inputs tick, clear, limit and outputs cnt, wrap.
- The FSM, shadow regs and output compare stay in the top module.

Test Plan:
- Reset/idle: rst=0 mid-run, asynchronously between edges -> pwm_out, period_end, cnt at 0 before the next clk edge; state=IDLE.
- Basic PWM, macro undefined:
  - Stimulus: period=9, duty=3, cfg_load, en=1, tick_in every 4th clk.
  - Response: pwm_out high 3 ticks and low 7 ticks; period_end pulses once per 10 ticks, width 1 clk.
- Soft start, macro defined:
  - Stimulus: period=3, duty=2.
  - Response: duty_act 0,1,2 across successive periods; pwm_out high 0,1,2 ticks; ramp_done rises at the second wrap.
- Double buffer:
  - Stimulus: in RUN with duty=3, cfg_load duty=7 mid-period.
  - Response: the current period is still 3 high; the next period is 7 high; no glitch.
- Boundaries: duty=0 -> pwm_out constant 0; duty=12 with period=9 -> constant 1; period=0 -> period_end on every tick.
- en drop coincident with a wrap -> period_end=1 that cycle, then state=IDLE and pwm_out=0 on the next edge; re-enable applies retained staging values.

Source files
------------

// File: rtl/tick_pwm_gen_pkg.sv
// Shared types and constants for the tick-driven PWM generator.
package pwm_pkg;

   localparam int unsigned WIDTH_DEF = 8;

   // Reset values for the period/duty registers; cast down to WIDTH at the use site.
   localparam logic [63:0] PERIOD_RST = '1;
   localparam logic [63:0] DUTY_RST   = '0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RAMP = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

endpackage

// File: rtl/tick_pwm_gen_if.sv
// Control/status bundle between the PWM generator and its controller.
interface tick_pwm_gen_if #(parameter int unsigned WIDTH = pwm_pkg::WIDTH_DEF);
   logic             tick_in;
   logic             en;
   logic [WIDTH-1:0] period;
   logic [WIDTH-1:0] duty;
   logic             cfg_load;
   logic             pwm_out;
   logic             period_end;
   logic             ramp_done;
   logic [1:0]       state;

   modport master (
      output tick_in, en, period, duty, cfg_load,
      input  pwm_out, period_end, ramp_done, state
   );

   modport slave (
      input  tick_in, en, period, duty, cfg_load,
      output pwm_out, period_end, ramp_done, state
   );
endinterface

// File: rtl/tick_pwm_gen_counter.sv
// Period counter: runs 0..limit on tick, wraps to 0, cleared while stopped.
module tick_period_counter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic             clear,
   input  logic [WIDTH-1:0] limit,
   output logic [WIDTH-1:0] cnt,
   output logic             wrap,
   output logic [WIDTH-1:0] cnt_next_c
);

   assign wrap = tick && (cnt == limit);

   always_comb begin
      cnt_next_c = cnt;
      if (clear || wrap) begin
         cnt_next_c = '0;
      end else if (tick) begin
         cnt_next_c = cnt + WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else begin
         cnt <= cnt_next_c;
      end
   end

endmodule

// File: rtl/tick_pwm_gen.sv
// Tick-enabled PWM with double-buffered period/duty.
// Define TICK_PWM_SOFT_START_EN to ramp duty from 0 through the RAMP state.
module tick_pwm_gen
   import pwm_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF
) (
   input  logic          clk,
   input  logic          rst,
   tick_pwm_gen_if.slave bus
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] period_stg, duty_stg, period_sh, duty_sh, duty_act;
   logic [WIDTH-1:0] period_stg_d, duty_stg_d, period_sh_d, duty_sh_d, duty_act_d;
   logic             load_pend, load_pend_d, pend_eff, apply;
   logic             active, start, advance, clear, wrap;
   logic             pwm_q, pwm_d, period_end_q, ramp_done_q;
   logic [WIDTH-1:0] cnt, cnt_next;

   assign active  = (state_q == ST_RAMP) || (state_q == ST_RUN);
   assign start   = (state_q == ST_IDLE) && bus.en;
   assign advance = bus.tick_in && active;
   assign clear   = !bus.en || !active;

   tick_period_counter #(.WIDTH(WIDTH)) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .tick       (advance),
      .clear      (clear),
      .limit      (period_sh),
      .cnt        (cnt),
      .wrap       (wrap),
      .cnt_next_c (cnt_next)
   );

   // Staging/shadow: a cfg_load landing on the boundary edge is applied immediately.
   always_comb begin
      period_stg_d = bus.cfg_load ? bus.period : period_stg;
      duty_stg_d   = bus.cfg_load ? bus.duty   : duty_stg;
      pend_eff     = load_pend || bus.cfg_load;
      apply        = bus.en && pend_eff && (wrap || start);
      period_sh_d  = apply ? period_stg_d : period_sh;
      duty_sh_d    = apply ? duty_stg_d   : duty_sh;
      load_pend_d  = apply ? 1'b0 : pend_eff;
   end

   // Next state and active duty.
   always_comb begin
      state_d    = state_q;
      duty_act_d = duty_act;
      case (state_q)
         ST_IDLE: begin
            duty_act_d = '0;
            if (bus.en) begin
`ifdef TICK_PWM_SOFT_START_EN
               state_d = ST_RAMP;
`else
               state_d    = ST_RUN;
               duty_act_d = duty_sh_d;
`endif
            end
         end
`ifdef TICK_PWM_SOFT_START_EN
         ST_RAMP: begin
            if (wrap) begin
               duty_act_d = (duty_act < duty_sh_d) ? duty_act + WIDTH'(1) : duty_sh_d;
               if (duty_act_d == duty_sh_d) state_d = ST_RUN;
            end else if (duty_act == duty_sh) begin
               state_d = ST_RUN;
            end
         end
`endif
         ST_RUN: begin
            if (wrap) duty_act_d = duty_sh_d;
         end
         default: begin
            state_d    = ST_IDLE;
            duty_act_d = '0;
         end
      endcase
      if (!bus.en) begin
         state_d    = ST_IDLE;
         duty_act_d = '0;
      end
   end

   assign pwm_d = (state_d != ST_IDLE) && (cnt_next < duty_act_d);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         period_stg   <= WIDTH'(PERIOD_RST);
         duty_stg     <= WIDTH'(DUTY_RST);
         period_sh    <= WIDTH'(PERIOD_RST);
         duty_sh      <= WIDTH'(DUTY_RST);
         load_pend    <= 1'b0;
         duty_act     <= '0;
         pwm_q        <= 1'b0;
         period_end_q <= 1'b0;
         ramp_done_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         period_stg   <= period_stg_d;
         duty_stg     <= duty_stg_d;
         period_sh    <= period_sh_d;
         duty_sh      <= duty_sh_d;
         load_pend    <= load_pend_d;
         duty_act     <= duty_act_d;
         pwm_q        <= pwm_d;
         period_end_q <= wrap;
         ramp_done_q  <= (state_d == ST_RUN);
      end
   end

   assign bus.pwm_out    = pwm_q;
   assign bus.period_end = period_end_q;
   assign bus.ramp_done  = ramp_done_q;
   assign bus.state      = state_q;

endmodule

// File: tb/tb_tick_pwm_gen.sv
// Scoreboard bench: each PWM period's high-tick count and length are checked against expected segments.
module tb_tick_pwm_gen;
   import pwm_pkg::*;

   localparam int unsigned W = 8;

   typedef struct {
      int high;
      int len;
   } seg_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic auto_tick = 1'b0;
   logic auto_t = 1'b0;
   logic man_tick = 1'b0;
   logic adv_d = 1'b0;
   int   phase = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   seg_t exp_q[$];

   tick_pwm_gen_if #(.WIDTH(W)) bus ();

   tick_pwm_gen #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   assign bus.tick_in = auto_tick ? auto_t : man_tick;

   initial begin
      forever begin
         @(negedge clk);
         phase  = (phase + 1) % 4;
         auto_t = (phase == 0);
      end
   end

   always @(posedge clk) begin
      adv_d <= bus.tick_in && bus.en && (bus.state == 2'd1 || bus.state == 2'd2);
   end

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: accumulates one PWM period and compares it at each period_end.
   initial begin
      int   high;
      int   len;
      bit   in_p;
      seg_t e;
      high = 0;
      len  = 0;
      in_p = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.period_end && in_p) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_period: got high=%0d len=%0d, expected none", high, len);
            end else begin
               e = exp_q.pop_front();
               check("seg_high", high, e.high);
               check("seg_len", len, e.len);
            end
         end
         if (!rst || bus.state == 2'd0) begin
            in_p = 1'b0;
         end else if (bus.period_end || !in_p) begin
            in_p = 1'b1;
            high = int'(bus.pwm_out);
            len  = 1;
         end else if (adv_d) begin
            high += int'(bus.pwm_out);
            len++;
         end
      end
   end

   function automatic int mn(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   task automatic push(input int h, input int l, input int n);
      seg_t s;
      s.high = h;
      s.len  = l;
      repeat (n) exp_q.push_back(s);
   endtask

   task automatic push_ramp(input int per, input int duty);
      int n;
      n = 0;
`ifdef TICK_PWM_SOFT_START_EN
      n = duty;
`endif
      for (int k = 0; k < n; k++) push(mn(k, per + 1), per + 1, 1);
   endtask

   task automatic drain(input int budget);
      int c;
      c = 0;
      while (exp_q.size() != 0 && c < budget) begin
         @(negedge clk);
         c++;
      end
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain_timeout: got %0d entries left, expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic load(input int per, input int duty);
      @(negedge clk);
      bus.period   = W'(per);
      bus.duty     = W'(duty);
      bus.cfg_load = 1'b1;
      @(negedge clk);
      bus.cfg_load = 1'b0;
   endtask

   task automatic run_case(input int per, input int duty, input int nsteady);
      int nramp;
      nramp = 0;
`ifdef TICK_PWM_SOFT_START_EN
      nramp = duty;
`endif
      bus.en = 1'b0;
      load(per, duty);
      bus.en = 1'b1;
      push_ramp(per, duty);
      push(mn(duty, per + 1), per + 1, nsteady);
      drain((nramp + nsteady + 1) * (per + 1) * 4 + 40);
   endtask

   task automatic man_pulse();
      man_tick = 1'b1;
      @(negedge clk);
      man_tick = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int first_high;
      bus.en       = 1'b0;
      bus.period   = '0;
      bus.duty     = '0;
      bus.cfg_load = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_pwm", int'(bus.pwm_out), 0);
      check("rst_period_end", int'(bus.period_end), 0);
      check("rst_ramp_done", int'(bus.ramp_done), 0);
      check("rst_state", int'(bus.state), int'(ST_IDLE));
      rst       = 1'b1;
      auto_tick = 1'b1;

      // ticks while idle must not start anything
      repeat (12) @(negedge clk);
      check("idle_state", int'(bus.state), int'(ST_IDLE));
      check("idle_pwm", int'(bus.pwm_out), 0);

      run_case(9, 3, 3);
      check("run_state", int'(bus.state), int'(ST_RUN));
      check("run_ramp_done", int'(bus.ramp_done), 1);

      // new duty loaded mid-period only takes effect at the next period
      repeat (5) @(negedge clk);
      load(9, 7);
      push(3, 10, 1);
      push(7, 10, 2);
      drain(4 * 10 * 4 + 40);
      bus.en = 1'b0;

      run_case(9, 0, 2);
      bus.en = 1'b0;
      run_case(9, 12, 2);
      bus.en = 1'b0;
      run_case(0, 0, 3);
      bus.en = 1'b0;
      run_case(0, 1, 3);
      bus.en = 1'b0;

      // en falls on the same edge as a wrap; staging written meanwhile must survive
      auto_tick = 1'b0;
      load(3, 1);
      bus.en = 1'b1;
      @(negedge clk);
      first_high = 1;
`ifdef TICK_PWM_SOFT_START_EN
      first_high = 0;
`endif
      push(first_high, 4, 1);
      man_pulse();
      man_pulse();
      load(3, 2);
      man_pulse();
      man_tick = 1'b1;
      bus.en   = 1'b0;
      @(negedge clk);
      man_tick = 1'b0;
      check("endrop_period_end", int'(bus.period_end), 1);
      check("endrop_state", int'(bus.state), int'(ST_IDLE));
      check("endrop_pwm", int'(bus.pwm_out), 0);
      @(negedge clk);
      check("endrop_pulse_width", int'(bus.period_end), 0);
      check("endrop_seg_done", exp_q.size(), 0);
      exp_q.delete();

      auto_tick = 1'b1;
      bus.en    = 1'b1;
      push_ramp(3, 2);
      push(2, 4, 2);
      drain(5 * 4 * 4 + 40);
      bus.en = 1'b0;

      // asynchronous reset between edges while the output is high
      run_case(9, 12, 1);
      check("pre_rst_pwm", int'(bus.pwm_out), 1);
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("async_rst_pwm", int'(bus.pwm_out), 0);
      check("async_rst_period_end", int'(bus.period_end), 0);
      check("async_rst_state", int'(bus.state), int'(ST_IDLE));
      exp_q.delete();
      @(negedge clk);
      rst = 1'b1;

      // pending loads were lost: reset shadow gives a long period with zero duty
      repeat (40) @(negedge clk);
      check("post_rst_state", int'(bus.state), int'(ST_RUN));
      check("post_rst_pwm", int'(bus.pwm_out), 0);
      check("post_rst_period_end", int'(bus.period_end), 0);
      bus.en = 1'b0;
      repeat (4) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
